// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 codes,
// byte-enable generation and access legality.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_of(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_legal(
    input logic       write,
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = !write;
      F3_HU:   ok = !write && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bram_be.sv
// DEPTH x 32 single-port synchronous RAM with
// per-byte write enables and a registered, enabled read.
module bram_be #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clock,
  input  logic [3:0]               we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/load_store_ram.sv
// Byte-addressed data RAM with RISC-V load/store
// semantics behind a single-slot valid/ready pipe.
module load_store_ram
  import lsu_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error
);

  localparam int AW = $clog2(DEPTH);

  logic          accept;
  logic          legal;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_addr;

  logic          err_q;
  logic          ld_ok;
  logic [1:0]    ld_off;
  logic [2:0]    ld_f3;
  logic [31:0]   lane;
  logic [31:0]   rdata_al;

  // Upper address bits alias onto the RAM.
  assign off         = req_addr[1:0];
  assign idx         = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[ADDR_W-1:AW+2];

  assign req_ready = !reset && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign legal     = is_legal(req_write, req_funct3, off);

  assign ram_re = accept && !req_write && legal;
  assign ram_we = (accept && req_write && legal)
                ? be_of(req_funct3, off) : 4'b0000;

  always_comb begin
    ram_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00:   ram_wdata = {4{req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{req_wdata[15:0]}};
      default: ram_wdata = req_wdata;
    endcase
  end

  bram_be #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      err_q      <= 1'b0;
      ld_ok      <= 1'b0;
      ld_off     <= 2'b00;
      ld_f3      <= F3_B;
    end else if (accept) begin
      resp_valid <= 1'b1;
      err_q      <= !legal;
      ld_ok      <= !req_write && legal;
      ld_off     <= off;
      ld_f3      <= req_funct3;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign lane = ram_rdata >> {ld_off, 3'b000};

  always_comb begin
    rdata_al = '0;
    unique case (1'b1)
      ld_f3 == F3_B:  rdata_al = {{24{lane[7]}}, lane[7:0]};
      ld_f3 == F3_BU: rdata_al = {24'd0, lane[7:0]};
      ld_f3 == F3_H:  rdata_al = {{16{lane[15]}}, lane[15:0]};
      ld_f3 == F3_HU: rdata_al = {16'd0, lane[15:0]};
      ld_f3 == F3_W:  rdata_al = ram_rdata;
      default:        rdata_al = '0;
    endcase
  end

  assign resp_rdata = (resp_valid && ld_ok) ? rdata_al : 32'd0;
  assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_ram.sv
// Directed and random checks of load_store_ram against
// a byte-array reference model.
module tb_load_store_ram;

  localparam int DEPTH = 16;
  localparam int NB    = 4 * DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks = 0;
  int passed = 0;
  logic [7:0]  mm [NB];
  logic [31:0] last_rd;

  always #5 clock = ~clock;

  load_store_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legal_m(
    input logic w, input logic [2:0] f3, input logic [31:0] a
  );
    int sz;
    sz = size_of(f3);
    if (sz == 0) return 0;
    if (w && f3[2]) return 0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] load_m(
    input logic [2:0] f3, input logic [31:0] a
  );
    int b;
    logic [31:0] v;
    b = a % NB;
    case (f3)
      3'b000: v = {{24{mm[b][7]}}, mm[b]};
      3'b100: v = {24'd0, mm[b]};
      3'b001: v = {{16{mm[b+1][7]}}, mm[b+1], mm[b]};
      3'b101: v = {16'd0, mm[b+1], mm[b]};
      default: v = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endcase
    return v;
  endfunction

  task automatic model(
    input logic w, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d,
    output logic e_err, output logic [31:0] e_rd
  );
    e_err = !legal_m(w, f3, a);
    e_rd  = '0;
    if (!e_err && w) begin
      for (int i = 0; i < size_of(f3); i++)
        mm[(a % NB) + i] = d[8*i +: 8];
    end else if (!e_err) begin
      e_rd = load_m(f3, a);
    end
  endtask

  task automatic drive(
    input logic w, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d
  );
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic xact(
    input string tag, input logic w, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d
  );
    logic e_err;
    logic [31:0] e_rd;
    model(w, f3, a, d, e_err, e_rd);
    resp_ready = 1'b1;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    drive(w, f3, a, d);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk({tag, " valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " err"}, 32'(resp_error), 32'(e_err));
    chk({tag, " rdata"}, resp_rdata, e_rd);
    last_rd = resp_rdata;
    @(posedge clock); #1;
  endtask

  initial begin
    logic e_err;
    logic [31:0] e_rd;
    logic [31:0] hold;

    #3;
    chk("rst valid", 32'(resp_valid), 32'd0);
    chk("rst err", 32'(resp_error), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;

    for (int i = 0; i < DEPTH; i++)
      xact("init", 1'b1, 3'b010, 32'(4*i), 32'd0);

    // 1: word store, word/byte loads
    xact("t1 sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    xact("t1 lw", 1'b0, 3'b010, 32'h10, 32'd0);
    chk("t1 lw const", last_rd, 32'hDEADBEEF);
    xact("t1 lb", 1'b0, 3'b000, 32'h13, 32'd0);
    chk("t1 lb const", last_rd, 32'hFFFFFFDE);
    xact("t1 lbu", 1'b0, 3'b100, 32'h13, 32'd0);
    chk("t1 lbu const", last_rd, 32'h000000DE);

    // 2: sub-word stores
    xact("t2 sb", 1'b1, 3'b000, 32'h21, 32'hFFFFFF5A);
    xact("t2 lw", 1'b0, 3'b010, 32'h20, 32'd0);
    chk("t2 lw const", last_rd, 32'h00005A00);
    xact("t2 sh", 1'b1, 3'b001, 32'h22, 32'hABCD1234);
    xact("t2 lw2", 1'b0, 3'b010, 32'h20, 32'd0);
    chk("t2 lw2 const", last_rd, 32'h12345A00);
    xact("t2 lh", 1'b0, 3'b001, 32'h22, 32'd0);
    chk("t2 lh const", last_rd, 32'h00001234);

    // 3: faults
    xact("t3 sw0", 1'b1, 3'b010, 32'h00, 32'h11223344);
    xact("t3 lw mis", 1'b0, 3'b010, 32'h02, 32'd0);
    xact("t3 sh mis", 1'b1, 3'b001, 32'h03, 32'hFFFF);
    xact("t3 ld 011", 1'b0, 3'b011, 32'h00, 32'd0);
    xact("t3 st 100", 1'b1, 3'b100, 32'h00, 32'hAA);
    xact("t3 lw0", 1'b0, 3'b010, 32'h00, 32'd0);
    chk("t3 lw0 const", last_rd, 32'h11223344);

    // 4: back-to-back store then load
    resp_ready = 1'b1;
    model(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, e_err, e_rd);
    drive(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(posedge clock); #1;
    chk("t4 sw valid", 32'(resp_valid), 32'd1);
    chk("t4 sw rdata", resp_rdata, 32'd0);
    chk("t4 ready", 32'(req_ready), 32'd1);
    drive(1'b0, 3'b010, 32'h40, 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("t4 lw valid", 32'(resp_valid), 32'd1);
    chk("t4 lw rdata", resp_rdata, 32'hCAFEF00D);
    @(posedge clock); #1;
    chk("t4 drained", 32'(resp_valid), 32'd0);

    // 5: backpressure
    hold = load_m(3'b010, 32'h40);
    resp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h40, 32'd0);
    @(posedge clock); #1;
    drive(1'b0, 3'b010, 32'h10, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5 stall ready", 32'(req_ready), 32'd0);
      chk("t5 stall valid", 32'(resp_valid), 32'd1);
      chk("t5 stall rdata", resp_rdata, hold);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("t5 release ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("t5 next valid", 32'(resp_valid), 32'd1);
    chk("t5 next rdata", resp_rdata, 32'hDEADBEEF);
    @(posedge clock); #1;
    chk("t5 drained", 32'(resp_valid), 32'd0);

    // 6: async reset with a pending fault response
    resp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h22, 32'd0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("t6 pend err", 32'(resp_error), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6 rst valid", 32'(resp_valid), 32'd0);
    chk("t6 rst err", 32'(resp_error), 32'd0);
    chk("t6 rst rdata", resp_rdata, 32'd0);
    chk("t6 rst ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    #1;
    xact("t6 lw", 1'b0, 3'b010, 32'h10, 32'd0);
    chk("t6 lw const", last_rd, 32'hDEADBEEF);
    xact("t6 alias", 1'b0, 3'b010, 32'(16'h10 + NB), 32'd0);
    chk("t6 alias const", last_rd, 32'hDEADBEEF);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 2*NB - 1);
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      xact("rnd", 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
